// File: rtl/paddle_555_emulator.sv
// rtl/paddle_555_emulator.sv - 555 monostable paddle emulator with debounced up/down position control
module paddle_555_emulator #(
    parameter int p_MIN_CYCLES  = 2500,
    parameter int p_STEP_CYCLES = 50,
    parameter int p_POS_MAX     = 479,
    parameter int p_POS_RESET   = 240,
    parameter int p_DEBOUNCE    = 250000,
    parameter int p_REPEAT      = 250000
) (
    input  logic                             i_Clk,
    input  logic                             i_Reset,
    input  logic                             i_555_Trigger,
    input  logic                             i_Up,
    input  logic                             i_Down,
    output logic                             o_555_Output,
    output logic                             o_Busy,
    output logic [$clog2(p_POS_MAX+1)-1:0]   o_Position
);
    localparam int c_POS_W = $clog2(p_POS_MAX + 1);
    localparam int c_CNT_W = $clog2(p_MIN_CYCLES + p_POS_MAX * p_STEP_CYCLES + 1);
    localparam int c_DB_W  = $clog2(p_DEBOUNCE + 1);
    localparam int c_RP_W  = $clog2(p_REPEAT + 1);

    typedef enum logic {ST_IDLE, ST_PULSE} state_t;

    logic [1:0]         trig_sync_q, up_sync_q, dn_sync_q;
    logic [1:0]         trig_vld_q;
    logic               trig_prev_q;
    logic               trig_fall;
    logic [1:0]         btn_sync, btn_deb_q, cmd_prev_q;
    logic [c_DB_W-1:0]  db_cnt_q [2];
    logic [c_RP_W-1:0]  rep_q, rep_d;
    logic [c_POS_W-1:0] pos_q, pos_d;
    logic               do_step;
    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d, pulse_len;
    logic               out_q, out_d;

    // trig_vld_q marks when the synchronizer holds real samples rather than its reset value,
    // so a trigger held low across reset release never looks like a fresh falling edge.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            trig_sync_q <= 2'b11;
            up_sync_q   <= 2'b00;
            dn_sync_q   <= 2'b00;
            trig_vld_q  <= 2'b00;
            trig_prev_q <= 1'b0;
        end else begin
            trig_sync_q <= {trig_sync_q[0], i_555_Trigger};
            up_sync_q   <= {up_sync_q[0], i_Up};
            dn_sync_q   <= {dn_sync_q[0], i_Down};
            trig_vld_q  <= {trig_vld_q[0], 1'b1};
            trig_prev_q <= trig_sync_q[1] & trig_vld_q[1];
        end
    end

    assign trig_fall = ~trig_sync_q[1] & trig_prev_q;
    assign btn_sync  = {dn_sync_q[1], up_sync_q[1]};

    always_ff @(posedge i_Clk) begin
        for (int b = 0; b < 2; b++) begin
            if (i_Reset) begin
                btn_deb_q[b] <= 1'b0;
                db_cnt_q[b]  <= '0;
            end else if (btn_sync[b] == btn_deb_q[b]) begin
                db_cnt_q[b]  <= '0;
            end else if (db_cnt_q[b] == c_DB_W'(p_DEBOUNCE - 1)) begin
                btn_deb_q[b] <= btn_sync[b];
                db_cnt_q[b]  <= '0;
            end else begin
                db_cnt_q[b]  <= db_cnt_q[b] + c_DB_W'(1);
            end
        end
    end

    // A new single-button command steps at once; holding it steps every p_REPEAT cycles.
    always_comb begin
        pos_d   = pos_q;
        rep_d   = '0;
        do_step = 1'b0;
        if (btn_deb_q == 2'b01 || btn_deb_q == 2'b10) begin
            if (btn_deb_q != cmd_prev_q) begin
                do_step = 1'b1;
            end else if (rep_q == c_RP_W'(p_REPEAT - 1)) begin
                do_step = 1'b1;
            end else begin
                rep_d = rep_q + c_RP_W'(1);
            end
        end
        if (do_step) begin
            if (btn_deb_q[0] && pos_q != c_POS_W'(p_POS_MAX)) begin
                pos_d = pos_q + c_POS_W'(1);
            end else if (btn_deb_q[1] && pos_q != '0) begin
                pos_d = pos_q - c_POS_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pos_q      <= c_POS_W'(p_POS_RESET);
            rep_q      <= '0;
            cmd_prev_q <= 2'b00;
        end else begin
            pos_q      <= pos_d;
            rep_q      <= rep_d;
            cmd_prev_q <= btn_deb_q;
        end
    end

    assign pulse_len = c_CNT_W'(p_MIN_CYCLES) + c_CNT_W'(pos_q) * c_CNT_W'(p_STEP_CYCLES);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (trig_fall) begin
                state_d = ST_PULSE;
                cnt_d   = pulse_len;
            end
        end else begin
            if (cnt_q == c_CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - c_CNT_W'(1);
            end
        end
        out_d = (state_q == ST_PULSE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign o_555_Output = out_q;
    assign o_Busy       = out_q;
    assign o_Position   = pos_q;
endmodule

// File: tb/tb_paddle_555_emulator.sv
// tb/tb_paddle_555_emulator.sv - scoreboard bench for paddle_555_emulator
module tb_paddle_555_emulator;
    logic       clk = 1'b0;
    logic       rst, trig, up, dn;
    logic       out, busy;
    logic [2:0] pos;

    always #5 clk = ~clk;

    paddle_555_emulator #(
        .p_MIN_CYCLES(10), .p_STEP_CYCLES(2), .p_POS_MAX(7),
        .p_POS_RESET(3), .p_DEBOUNCE(4), .p_REPEAT(8)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_555_Trigger(trig), .i_Up(up), .i_Down(dn),
        .o_555_Output(out), .o_Busy(busy), .o_Position(pos)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_len_q[$], exp_start_q[$], obs_len_q[$], obs_start_q[$];
    int exp_pv_q[$], exp_pc_q[$], obs_pv_q[$], obs_pc_q[$];

    logic       prev_out = 1'b0;
    logic [2:0] prev_pos = 3'd3;
    int         run_len = 0;
    int         run_start = 0;

    always @(negedge clk) begin
        if (out === 1'b1 && prev_out !== 1'b1) begin
            run_start = cyc;
            run_len   = 1;
        end else if (out === 1'b1) begin
            run_len++;
        end else if (prev_out === 1'b1) begin
            obs_len_q.push_back(run_len);
            obs_start_q.push_back(run_start);
        end
        prev_out = out;
        if (pos !== prev_pos) begin
            obs_pv_q.push_back(int'(pos));
            obs_pc_q.push_back(cyc);
        end
        prev_pos = pos;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_pulse(output int ol, output int os, output int el, output int es);
        int t = 0;
        while (obs_len_q.size() == 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        el = -2; es = -2; ol = -1; os = -1;
        if (exp_len_q.size() != 0) begin
            el = exp_len_q.pop_front();
            es = exp_start_q.pop_front();
        end
        if (obs_len_q.size() != 0) begin
            ol = obs_len_q.pop_front();
            os = obs_start_q.pop_front();
        end
    endtask

    task automatic pop_pos(output int ov, output int oc, output int ev, output int ec);
        ev = -2; ec = -2; ov = -1; oc = -1;
        if (exp_pv_q.size() != 0) begin
            ev = exp_pv_q.pop_front();
            ec = exp_pc_q.pop_front();
        end
        if (obs_pv_q.size() != 0) begin
            ov = obs_pv_q.pop_front();
            oc = obs_pc_q.pop_front();
        end
    endtask

    task automatic clear_pos_q();
        obs_pv_q.delete();
        obs_pc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; trig = 1'b1; up = 1'b0; dn = 1'b0;
        tick(3);
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL reset_out: got %b want 0", out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (pos !== 3'd3) begin n_bad++; $display("FAIL reset_pos: got %0d want 3", pos); end
        rst = 1'b0;
        tick(6);
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL post_reset_out: got %b want 0", out); end
        obs_len_q.delete(); obs_start_q.delete();
        clear_pos_q();
    endtask

    task automatic test_single_pulse();
        int se, ol, os, el, es;
        tick(1);
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        tick(8);
        n_cmp++; if (out !== 1'b1 || busy !== out) begin
            n_bad++; $display("FAIL busy_track: got out=%b busy=%b want 1/1", out, busy);
        end
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL single_len: got %0d want %0d", ol, el); end
        n_cmp++; if (os !== es) begin n_bad++; $display("FAIL single_start: got %0d want %0d", os, es); end
        n_cmp++; if (pos !== 3'd3) begin n_bad++; $display("FAIL single_pos: got %0d want 3", pos); end
    endtask

    task automatic test_held_trigger();
        int se, ol, os, el, es;
        tick(1);
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(100); trig = 1'b1; tick(5);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL held_len: got %0d want %0d", ol, el); end
        n_cmp++; if (os !== es) begin n_bad++; $display("FAIL held_start: got %0d want %0d", os, es); end
        n_cmp++; if (obs_len_q.size() !== 0) begin
            n_bad++; $display("FAIL held_count: got %0d extra pulses want 0", obs_len_q.size());
        end
        tick(1);
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        tick(7); trig = 1'b0;
        tick(1); trig = 1'b1;
        tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL retrig_len: got %0d want %0d", ol, el); end
        n_cmp++; if (obs_len_q.size() !== 0) begin
            n_bad++; $display("FAIL retrig_count: got %0d extra pulses want 0", obs_len_q.size());
        end
    endtask

    task automatic test_end_boundary();
        int se, ol, os, el, es;
        tick(1);
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        while (cyc + 1 < se + 16) tick(1);
        trig = 1'b0; tick(3); trig = 1'b1;
        tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL end_len: got %0d want %0d", ol, el); end
        n_cmp++; if (obs_len_q.size() !== 0) begin
            n_bad++; $display("FAIL end_edge_ignored: got %0d extra pulses want 0", obs_len_q.size());
        end
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (os !== es) begin n_bad++; $display("FAIL end_next_start: got %0d want %0d", os, es); end
    endtask

    task automatic test_up_repeat();
        int su, ov, oc, ev, ec;
        clear_pos_q();
        tick(1);
        up = 1'b1; su = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            exp_pv_q.push_back(4 + k); exp_pc_q.push_back(su + 6 + 8 * k);
        end
        tick(40); up = 1'b0; tick(20);
        for (int k = 0; k < 4; k++) begin
            pop_pos(ov, oc, ev, ec);
            n_cmp++; if (ov !== ev) begin n_bad++; $display("FAIL up_val[%0d]: got %0d want %0d", k, ov, ev); end
            n_cmp++; if (oc !== ec) begin n_bad++; $display("FAIL up_cyc[%0d]: got %0d want %0d", k, oc, ec); end
        end
        n_cmp++; if (pos !== 3'd7 || obs_pv_q.size() !== 0) begin
            n_bad++; $display("FAIL up_saturate: got pos %0d extra %0d want 7/0", pos, obs_pv_q.size());
        end
        tick(1);
        dn = 1'b1; su = cyc + 1;
        for (int k = 0; k < 7; k++) begin
            exp_pv_q.push_back(6 - k); exp_pc_q.push_back(su + 6 + 8 * k);
        end
        tick(80); dn = 1'b0; tick(20);
        for (int k = 0; k < 7; k++) begin
            pop_pos(ov, oc, ev, ec);
            n_cmp++; if (ov !== ev || oc !== ec) begin
                n_bad++; $display("FAIL down[%0d]: got %0d@%0d want %0d@%0d", k, ov, oc, ev, ec);
            end
        end
        n_cmp++; if (pos !== 3'd0 || obs_pv_q.size() !== 0) begin
            n_bad++; $display("FAIL down_floor: got pos %0d extra %0d want 0/0", pos, obs_pv_q.size());
        end
    endtask

    task automatic test_pulse_latch();
        int se, su, ol, os, el, es, ov, oc, ev, ec;
        rst = 1'b1; tick(2); rst = 1'b0; tick(6);
        clear_pos_q();
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        up = 1'b1; su = cyc + 1;
        exp_pv_q.push_back(4); exp_pc_q.push_back(su + 6);
        tick(6); up = 1'b0;
        tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL latch_len: got %0d want %0d", ol, el); end
        pop_pos(ov, oc, ev, ec);
        n_cmp++; if (ov !== ev || oc !== ec) begin
            n_bad++; $display("FAIL latch_step: got %0d@%0d want %0d@%0d", ov, oc, ev, ec);
        end
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(18); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL latch_next_len: got %0d want %0d", ol, el); end
        n_cmp++; if (pos !== 3'd4) begin n_bad++; $display("FAIL latch_pos: got %0d want 4", pos); end
    endtask

    task automatic test_reset_mid_pulse();
        int se, ol, os, el, es;
        tick(1);
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(6); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        while (cyc < se + 8) tick(1);
        rst = 1'b1; tick(1);
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out: got %b want 0", out); end
        n_cmp++; if (pos !== 3'd3) begin n_bad++; $display("FAIL rst_mid_pos: got %0d want 3", pos); end
        rst = 1'b0; tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL rst_mid_len: got %0d want %0d", ol, el); end
        n_cmp++; if (obs_len_q.size() !== 0) begin
            n_bad++; $display("FAIL rst_mid_spurious: got %0d pulses want 0", obs_len_q.size());
        end
        rst = 1'b1; trig = 1'b0; tick(3);
        rst = 1'b0; tick(20);
        n_cmp++; if (obs_len_q.size() !== 0 || out !== 1'b0) begin
            n_bad++; $display("FAIL rst_held_low: got %0d pulses out=%b want 0/0", obs_len_q.size(), out);
        end
        trig = 1'b1; tick(4);
        trig = 1'b0; se = cyc + 1;
        exp_len_q.push_back(16); exp_start_q.push_back(se + 3);
        tick(1); trig = 1'b1;
        tick(30);
        pop_pulse(ol, os, el, es);
        n_cmp++; if (ol !== el || os !== es) begin
            n_bad++; $display("FAIL rst_fresh: got %0d@%0d want %0d@%0d", ol, os, el, es);
        end
    endtask

    task automatic test_glitch_and_both();
        int su, ov, oc, ev, ec;
        clear_pos_q();
        tick(1);
        up = 1'b1; tick(3); up = 1'b0; tick(20);
        n_cmp++; if (obs_pv_q.size() !== 0 || pos !== 3'd3) begin
            n_bad++; $display("FAIL glitch: got pos %0d changes %0d want 3/0", pos, obs_pv_q.size());
        end
        up = 1'b1; su = cyc + 1;
        exp_pv_q.push_back(4); exp_pc_q.push_back(su + 6);
        tick(4); up = 1'b0; tick(20);
        pop_pos(ov, oc, ev, ec);
        n_cmp++; if (ov !== ev || oc !== ec) begin
            n_bad++; $display("FAIL min_press: got %0d@%0d want %0d@%0d", ov, oc, ev, ec);
        end
        up = 1'b1; dn = 1'b1; tick(40);
        up = 1'b0; dn = 1'b0; tick(20);
        n_cmp++; if (obs_pv_q.size() !== 0 || pos !== 3'd4) begin
            n_bad++; $display("FAIL both_held: got pos %0d changes %0d want 4/0", pos, obs_pv_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pulse();
        test_held_trigger();
        test_end_boundary();
        test_up_repeat();
        test_pulse_latch();
        test_reset_mid_pulse();
        test_glitch_and_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/paddle_555_emulator.md
PADDLE_555_EMULATOR -- requirements
Module: paddle_555_emulator

Interface
REQ-001 SHALL have parameter p_MIN_CYCLES, default 2500, giving the pulse length in clocks at position 0.
REQ-002 SHALL have parameter p_STEP_CYCLES, default 50, giving the extra pulse clocks added per position unit.
REQ-003 SHALL have parameter p_POS_MAX, default 479, giving the highest paddle position.
REQ-004 SHALL have parameter p_POS_RESET, default 240, giving the position loaded at reset.
REQ-005 SHALL have parameter p_DEBOUNCE, default 250000, giving the clocks a button input must be stable before it is accepted.
REQ-006 SHALL have parameter p_REPEAT, default 250000, giving the auto-repeat period in clocks while a button is held.
REQ-007 i_Clk  input  1  sole clock, all logic on its rising edge.
REQ-008 i_Reset  input  1  synchronous, active-high reset.
REQ-009 i_555_Trigger  input  1  async, active-low trigger from the paddle reader.
REQ-010 i_Up  input  1  async, active-high button that increments the position.
REQ-011 i_Down  input  1  async, active-high button that decrements the position.
REQ-012 o_555_Output  output  1  monostable pulse, high while timing.
REQ-013 o_Busy  output  1  high while a pulse is in progress.
REQ-014 o_Position  output  clog2(p_POS_MAX+1)  current paddle position.

Function
REQ-015 i_555_Trigger, i_Up and i_Down SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 Trigger edge detect SHALL fire when the synchronized trigger is low and was high the previous cycle; a trigger held low SHALL yield exactly one pulse.
REQ-017 FSM SHALL have exactly two states, IDLE and PULSE; IDLE goes to PULSE on a trigger edge, PULSE goes to IDLE when the counter expires.
REQ-018 On entry to PULSE, the pulse length N = p_MIN_CYCLES + o_Position*p_STEP_CYCLES SHALL be latched; position changes during the pulse SHALL NOT alter it.
REQ-019 o_555_Output SHALL rise 3 clocks after the first i_Clk edge that samples i_555_Trigger low following a high sample, and SHALL stay high exactly N cycles.
REQ-020 o_Busy SHALL equal o_555_Output.
REQ-021 Trigger edges while in PULSE SHALL be ignored, with no queuing or extension.
REQ-022 A trigger edge in the same cycle the pulse ends SHALL be ignored; the next falling edge starts a new pulse.
REQ-023 The pulse counter width SHALL hold p_MIN_CYCLES + p_POS_MAX*p_STEP_CYCLES without overflow.
REQ-024 Each button SHALL be debounced: the debounced level changes only after the synchronized input differs from it for p_DEBOUNCE consecutive cycles.
REQ-025 A debounced rising edge SHALL step the position by 1 on the next cycle, then by 1 every p_REPEAT cycles while the button stays held.
REQ-026 Up and Down both debounced-high SHALL cause no movement and SHALL restart the repeat timer.
REQ-027 Position SHALL saturate at 0 and p_POS_MAX, with no wrap-around.

Reset
REQ-028 While i_Reset is high at a clock edge: FSM = IDLE, o_555_Output = 0, o_Busy = 0, o_Position = p_POS_RESET, all counters = 0, debounced levels = 0, synchronizer flops = trigger 1 / buttons 0.
REQ-029 Reset asserted mid-pulse SHALL drop o_555_Output the next cycle; a trigger held low through reset release SHALL NOT start a pulse until it returns high and falls again.

Verification
Bench params: p_MIN_CYCLES=10, p_STEP_CYCLES=2, p_POS_MAX=7, p_POS_RESET=3, p_DEBOUNCE=4, p_REPEAT=8.
REQ-030 Reset, then a 1-cycle low on trigger -> o_555_Output high exactly 16 cycles starting 3 cycles after the sample, o_Position=3.
REQ-031 Trigger held low for 100 cycles -> exactly one 16-cycle pulse; a second falling edge 5 cycles into a pulse -> no extension.
REQ-032 i_Up held 40 cycles -> position 4 at cycle 2+4+1, then 5, 6, 7 at 8-cycle intervals, then held at 7; i_Down held from 0 -> stays 0.
REQ-033 Trigger at position 3, i_Up pulses position to 4 mid-pulse -> that pulse stays 16 cycles and the next pulse is 18 cycles.
REQ-034 i_Reset high on cycle 6 of a pulse -> output 0 the next cycle, position 3, no pulse until a fresh trigger edge.
REQ-035 i_Up glitching high for 3 cycles -> no position change; i_Up and i_Down held together -> position unchanged.
